// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   - MIPS funct codes for the ops the unit decodes
//   - FSM state encoding
//   - cond_neg(): conditional two's-complement negate, used for operand
//     magnitudes and result sign correction at any width up to MAX_W
package muldiv_pkg;

  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  // Callers zero-extend into MAX_W and truncate the result back with a size
  // cast; the low bits of a wide negate equal the narrow negate.
  localparam int unsigned MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] v,
                                                input logic             neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// muldiv_core: unsigned iterative datapath, one step per cycle.
//   Multiply: shift-add, product accumulates in {acc, q}; q starts as the
//             multiplier, m holds the multiplicand.
//   Divide:   restoring, q starts as the dividend and shifts in one quotient
//             bit per step; acc ends as the remainder, m holds the divisor.
// Ports:
//   clk, reset   clock, async active-low reset
//   load         capture operand magnitudes, count = WIDTH
//   step         perform one iteration
//   is_div       mode select, sampled with load
//   op_a, op_b   operand magnitudes (dividend/multiplicand, divisor/multiplier)
//   acc, q       working registers (high/low result halves)
//   last         current step is the final one
module muldiv_core #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] q,
  output logic             last
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] m;
  logic [CNT_W-1:0] count;
  logic             mode_div;

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  assign sum    = {1'b0, acc} + {1'b0, m};
  assign rem_sh = {acc, q[WIDTH-1]};
  // rem_sh < 2*m always holds, so bit WIDTH of diff is a clean borrow flag.
  assign diff   = rem_sh - {1'b0, m};

  assign last = (count == CNT_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc      <= '0;
      q        <= '0;
      m        <= '0;
      count    <= '0;
      mode_div <= 1'b0;
    end else if (load) begin
      acc      <= '0;
      q        <= is_div ? op_a : op_b;
      m        <= is_div ? op_b : op_a;
      count    <= CNT_W'(WIDTH);
      mode_div <= is_div;
    end else if (step) begin
      count <= count - CNT_W'(1);
      if (mode_div) begin
        if (!diff[WIDTH]) begin
          acc <= diff[WIDTH-1:0];
          q   <= {q[WIDTH-2:0], 1'b1};
        end else begin
          acc <= rem_sh[WIDTH-1:0];
          q   <= {q[WIDTH-2:0], 1'b0};
        end
      end else if (q[0]) begin
        acc <= sum[WIDTH:1];
        q   <= {sum[0], q[WIDTH-1:1]};
      end else begin
        acc <= {1'b0, acc[WIDTH-1:1]};
        q   <= {acc[0], q[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MIPS multiply/divide unit owning HI/LO.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | ready; accepts mult/multu/div/divu, mfhi/mflo read only
//   RUN   | core iterating, one step per cycle for WIDTH cycles
//   FIX   | sign-correct core result, write HI/LO, done next cycle
//
// Ports:
//   clk, reset        clock, async active-low reset
//   start, funct      op request (sampled only while ready)
//   a, b              rs / rt operands
//   ready, busy       idle / op in progress
//   done              one-cycle pulse after HI/LO written
//   div0              last div/divu had b==0 (valid with done)
//   illegal           one-cycle pulse after start with unknown funct
//   hi, lo            architectural HI/LO
//   result            combinational HI/LO read for mfhi/mflo, else 0
// WIDTH must be <= 32 so the 2*WIDTH product fits the package negate helper.
module muldiv_seq #(
  parameter int WIDTH   = 16,
  parameter int FUNCT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic               div0,
  output logic               illegal,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic [WIDTH-1:0]   result
);

  import muldiv_pkg::*;

  localparam int PW = 2 * WIDTH;

  localparam logic [FUNCT_W-1:0] F_MULT  = FUNCT_W'(FN_MULT);
  localparam logic [FUNCT_W-1:0] F_MULTU = FUNCT_W'(FN_MULTU);
  localparam logic [FUNCT_W-1:0] F_DIV   = FUNCT_W'(FN_DIV);
  localparam logic [FUNCT_W-1:0] F_DIVU  = FUNCT_W'(FN_DIVU);
  localparam logic [FUNCT_W-1:0] F_MFHI  = FUNCT_W'(FN_MFHI);
  localparam logic [FUNCT_W-1:0] F_MFLO  = FUNCT_W'(FN_MFLO);

  state_t state, state_nxt;

  logic is_mult, is_multu, is_div, is_divu, is_mfhi, is_mflo;
  logic is_mulop, is_divop, is_signed, is_legal;
  logic a_neg, b_neg, b_zero, accept;
  logic [WIDTH-1:0] a_mag, b_mag;

  logic core_load, core_step, core_last;
  logic [WIDTH-1:0] core_acc, core_q;
  logic [PW-1:0]    prod;

  // Latched per-op controls. neg_lo is the product sign for multiply and
  // the quotient sign for divide (both a^b); neg_hi is the dividend sign.
  logic op_mul, neg_lo, neg_hi, div0_pend;

  assign is_mult  = (funct == F_MULT);
  assign is_multu = (funct == F_MULTU);
  assign is_div   = (funct == F_DIV);
  assign is_divu  = (funct == F_DIVU);
  assign is_mfhi  = (funct == F_MFHI);
  assign is_mflo  = (funct == F_MFLO);

  assign is_mulop  = is_mult | is_multu;
  assign is_divop  = is_div | is_divu;
  assign is_signed = is_mult | is_div;
  assign is_legal  = is_mulop | is_divop | is_mfhi | is_mflo;

  assign a_neg  = is_signed & a[WIDTH-1];
  assign b_neg  = is_signed & b[WIDTH-1];
  assign a_mag  = WIDTH'(cond_neg(MAX_W'(a), a_neg));
  assign b_mag  = WIDTH'(cond_neg(MAX_W'(b), b_neg));
  assign b_zero = (b == '0);

  assign ready  = (state == IDLE);
  assign busy   = ~ready;
  assign accept = ready & start & (is_mulop | is_divop);

  assign prod = {core_acc, core_q};

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .reset  (reset),
    .load   (core_load),
    .step   (core_step),
    .is_div (is_divop),
    .op_a   (a_mag),
    .op_b   (b_mag),
    .acc    (core_acc),
    .q      (core_q),
    .last   (core_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    core_load = 1'b0;
    core_step = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          core_load = 1'b1;
          // Divide by zero bypasses the iteration; the core still holds |a|.
          state_nxt = (is_divop && b_zero) ? FIX : RUN;
        end
      end
      RUN: begin
        core_step = 1'b1;
        if (core_last) state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
      div0      <= 1'b0;
      illegal   <= 1'b0;
      op_mul    <= 1'b0;
      neg_lo    <= 1'b0;
      neg_hi    <= 1'b0;
      div0_pend <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= ready & start & ~is_legal;
      if (accept) begin
        op_mul    <= is_mulop;
        neg_lo    <= a_neg ^ b_neg;
        neg_hi    <= a_neg;
        div0_pend <= is_divop & b_zero;
        div0      <= 1'b0;
      end
      if (state == FIX) begin
        done <= 1'b1;
        div0 <= div0_pend;
        if (op_mul) begin
          {hi, lo} <= PW'(cond_neg(MAX_W'(prod), neg_lo));
        end else if (div0_pend) begin
          // Re-applying the dividend sign to |a| restores the original a.
          hi <= WIDTH'(cond_neg(MAX_W'(core_q), neg_hi));
          lo <= '1;
        end else begin
          hi <= WIDTH'(cond_neg(MAX_W'(core_acc), neg_hi));
          lo <= WIDTH'(cond_neg(MAX_W'(core_q), neg_lo));
        end
      end
    end
  end

  always_comb begin
    result = '0;
    if (is_mfhi)      result = hi;
    else if (is_mflo) result = lo;
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed and randomized checks of muldiv_seq against an
// arithmetic reference model (64-bit integer multiply/divide).
module tb_muldiv_seq;

  localparam int W = 16;

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [5:0]   funct;
  logic [W-1:0] a, b;
  logic         ready, busy, done, div0, illegal;
  logic [W-1:0] hi, lo, result;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_hi, exp_lo;
  logic         exp_div0;

  logic [5:0] ops [4] = '{F_MULT, F_MULTU, F_DIV, F_DIVU};

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(W), .FUNCT_W(6)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .funct   (funct),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .div0    (div0),
    .illegal (illegal),
    .hi      (hi),
    .lo      (lo),
    .result  (result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the architectural operands.
  function automatic void model(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    longint p, q, r, sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (f)
      F_MULT:  begin p = sx * sy; {exp_hi, exp_lo} = p[2*W-1:0]; exp_div0 = 1'b0; end
      F_MULTU: begin p = longint'(x) * longint'(y); {exp_hi, exp_lo} = p[2*W-1:0]; exp_div0 = 1'b0; end
      default: begin
        if (y == '0) begin
          exp_hi = x; exp_lo = '1; exp_div0 = 1'b1;
        end else begin
          if (f == F_DIV) begin q = sx / sy; r = sx % sy; end
          else begin q = longint'(x) / longint'(y); r = longint'(x) % longint'(y); end
          exp_lo = q[W-1:0]; exp_hi = r[W-1:0]; exp_div0 = 1'b0;
        end
      end
    endcase
  endfunction

  // Call at a negedge; returns at the negedge where done is first seen.
  task automatic run_op(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit poke, input string tag);
    int n;
    int exp_lat;
    check({tag, " ready_pre"}, 32'(ready), 32'd1);
    start = 1'b1; funct = f; a = x; b = y;
    model(f, x, y);
    exp_lat = ((f == F_DIV || f == F_DIVU) && y == '0) ? 1 : W + 1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    check({tag, " busy"}, 32'(busy), 32'd1);
    check({tag, " done_low"}, 32'(done), 32'd0);
    while (!done && n < W + 4) begin
      if (poke && n == 3) begin
        start = 1'b1; funct = F_DIV; a = W'($urandom); b = W'($urandom);
      end else if (poke && n == 4) begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
    check({tag, " hi"}, 32'(hi), 32'(exp_hi));
    check({tag, " lo"}, 32'(lo), 32'(exp_lo));
    check({tag, " div0"}, 32'(div0), 32'(exp_div0));
    check({tag, " ready"}, 32'(ready), 32'd1);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) check("done_illegal_excl", 32'(done & illegal), 32'd0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dcount;
    logic [5:0]   f;
    logic [W-1:0] x, y;

    reset = 1'b1; start = 1'b0; funct = '0; a = '0; b = '0;
    #2 reset = 1'b0;
    #1;
    check("rst hi", 32'(hi), 32'd0);
    check("rst lo", 32'(lo), 32'd0);
    check("rst ready", 32'(ready), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst div0", 32'(div0), 32'd0);
    check("rst illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_op(F_MULT, 16'h0003, 16'hFFFB, 1'b0, "mult_neg");
    check("mult_neg illegal", 32'(illegal), 32'd0);
    run_op(F_MULTU, 16'hFFFF, 16'hFFFF, 1'b0, "multu_max");
    check("multu_max hi_const", 32'(hi), 32'hFFFE);

    // Register moves: combinational read, no state change, no done.
    start = 1'b1; funct = F_MFHI;
    #1 check("mfhi result", 32'(result), 32'hFFFE);
    @(posedge clk);
    @(negedge clk);
    funct = F_MFLO;
    #1 check("mflo result", 32'(result), 32'h0001);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("mf done", 32'(done), 32'd0);
    check("mf ready", 32'(ready), 32'd1);
    check("mf hi", 32'(hi), 32'hFFFE);
    funct = F_MULT;
    #1 check("result other", 32'(result), 32'd0);
    @(negedge clk);

    run_op(F_DIV, 16'hFFF9, 16'h0002, 1'b0, "div_neg");
    run_op(F_DIV, 16'h8000, 16'hFFFF, 1'b0, "div_ovf");
    run_op(F_DIVU, 16'h0064, 16'h0000, 1'b0, "divu_zero");
    run_op(F_MULTU, 16'h0002, 16'h0002, 1'b0, "after_div0");
    run_op(F_DIV, 16'h0007, 16'h0000, 1'b0, "div_zero_s");
    run_op(F_MULT, 16'h8000, 16'h8000, 1'b0, "mult_minmin");

    // Illegal funct: one-cycle flag, HI/LO untouched.
    @(negedge clk);
    start = 1'b1; funct = 6'h3F;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("illegal pulse", 32'(illegal), 32'd1);
    check("illegal done", 32'(done), 32'd0);
    check("illegal ready", 32'(ready), 32'd1);
    check("illegal hi", 32'(hi), 32'(exp_hi));
    check("illegal lo", 32'(lo), 32'(exp_lo));
    @(negedge clk);
    check("illegal clear", 32'(illegal), 32'd0);

    for (int i = 0; i < 40; i++) begin
      f = ops[$urandom_range(0, 3)];
      x = W'($urandom);
      y = W'($urandom);
      if (i % 7 == 0) y = '0;
      if (i % 11 == 5) begin x = 16'h8000; y = 16'hFFFF; end
      run_op(f, x, y, (i % 3 == 0), "rand");
      if (i % 5 == 0) begin
        funct = F_MFHI;
        #1 check("rand mfhi", 32'(result), 32'(exp_hi));
        funct = F_MFLO;
        #1 check("rand mflo", 32'(result), 32'(exp_lo));
      end
    end

    // Mid-op reset with an ignored start while busy.
    @(negedge clk);
    start = 1'b1; funct = F_MULT; a = 16'h1234; b = 16'h5678;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (n < 8) begin
      if (n == 5) begin start = 1'b1; funct = F_DIV; a = 16'h0010; b = 16'h0003; end
      else if (n == 6) start = 1'b0;
      @(negedge clk);
      n++;
    end
    reset = 1'b0;
    #1;
    exp_hi = '0; exp_lo = '0; exp_div0 = 1'b0;
    check("midrst hi", 32'(hi), 32'd0);
    check("midrst lo", 32'(lo), 32'd0);
    check("midrst ready", 32'(ready), 32'd1);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    dcount = 0;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("midrst no_done", 32'(dcount), 32'd0);
    check("midrst hi_after", 32'(hi), 32'd0);

    run_op(F_MULT, 16'hFFFF, 16'h0007, 1'b0, "post_rst");
    @(negedge clk);
    check("post_rst done_pulse", 32'(done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
